// File: rtl/spi_mem_responder.sv
// spi_mem_responder: SPI Mode 0 responder emulating a single-I/O serial program
// memory. It supports READ (0x03) and, when SPI_MEM_WRITE_EN is defined, WRITE (0x02).
// The frame is an 8-bit command, a 16-bit address and then 16-bit words, all MSB first.
// The address auto-increments while CS stays low.
// The internal 2^MEM_AW x 16 array is also writable through a parallel load port.
// Optional feature macro: SPI_MEM_WRITE_EN (undefined: 0x02 is an unsupported command).
module spi_mem_responder #(
  parameter int unsigned MEM_AW      = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_cs,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso_o,
  output logic              spi_miso_oe,
  input  logic              load_en,
  input  logic [MEM_AW-1:0] load_addr,
  input  logic [15:0]       load_data,
  output logic              busy,
  output logic              cmd_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_FETCH,
    S_READ,
`ifdef SPI_MEM_WRITE_EN
    S_WRITE,
`endif
    S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   cs_act;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   rise;
  logic                   fall;

  state_t            state;
  logic [3:0]        bit_cnt;
  logic [14:0]       rx_shift;
  logic [15:0]       rx_next;
  logic [15:0]       tx_shift;
  logic [15:0]       next_word;
  logic [MEM_AW-1:0] addr;
  logic              word_done;
  logic              pf_pending;
`ifdef SPI_MEM_WRITE_EN
  logic              is_write;
  logic              wr_pending;
  logic [MEM_AW-1:0] wr_addr;
  logic [15:0]       wr_data;
`endif

  logic [15:0]       mem [0:(1<<MEM_AW)-1];
  logic [15:0]       mem_rdata;
  logic [MEM_AW-1:0] rd_idx;

  // Address bits above MEM_AW alias by design.
  logic              unused_rx_bits;

  assign cs_act         = ~cs_sync[SYNC_STAGES-1];
  assign sclk_s         = sclk_sync[SYNC_STAGES-1];
  assign mosi_s         = mosi_sync[SYNC_STAGES-1];
  assign rise           = sclk_s & ~sclk_d;
  assign fall           = ~sclk_s & sclk_d;
  assign rx_next        = {rx_shift, mosi_s};
  assign spi_miso_o     = tx_shift[15];
  assign unused_rx_bits = ^rx_next;

  // Synchronize the SPI pins and register SCLK for edge detection.
  // Reset loads idle-line values (CS high, SCLK low), so that no false frame start is seen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_d    <= sclk_s;
    end
  end

  // Select the array read index.
  // On the last address bit or the last data bit, look ahead to the new address so that the word is ready one clk later.
  always_comb begin
    rd_idx = addr;
    if (cs_act && rise && bit_cnt == 4'd15) begin
      if (state == S_ADDR)
        rd_idx = rx_next[MEM_AW-1:0];
      else if (state == S_READ)
        rd_idx = addr + 1'b1;
    end
  end

  // Array: one synchronous read port, an SPI write port and the load port (load applied last, so it wins).
  always_ff @(posedge clk) begin
    mem_rdata <= mem[rd_idx];
`ifdef SPI_MEM_WRITE_EN
    if (wr_pending)
      mem[wr_addr] <= wr_data;
`endif
    if (load_en)
      mem[load_addr] <= load_data;
  end

  // Protocol FSM. A deasserted CS overrides every other event in the same clk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      next_word   <= '0;
      addr        <= '0;
      word_done   <= 1'b0;
      pf_pending  <= 1'b0;
      spi_miso_oe <= 1'b0;
      busy        <= 1'b0;
      cmd_err     <= 1'b0;
`ifdef SPI_MEM_WRITE_EN
      is_write    <= 1'b0;
      wr_pending  <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
`endif
    end else begin
      cmd_err <= 1'b0;
`ifdef SPI_MEM_WRITE_EN
      wr_pending <= 1'b0;
`endif
      if (pf_pending) begin
        next_word  <= mem_rdata;
        pf_pending <= 1'b0;
      end
      if (!cs_act) begin
        state       <= S_IDLE;
        busy        <= 1'b0;
        spi_miso_oe <= 1'b0;
        bit_cnt     <= '0;
        rx_shift    <= '0;
        tx_shift    <= '0;
        word_done   <= 1'b0;
        pf_pending  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state   <= S_CMD;
            busy    <= 1'b1;
            bit_cnt <= '0;
          end
          S_CMD: begin
            if (rise) begin
              rx_shift <= rx_next[14:0];
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                case (rx_next[7:0])
                  8'h03: begin
                    state <= S_ADDR;
`ifdef SPI_MEM_WRITE_EN
                    is_write <= 1'b0;
`endif
                  end
`ifdef SPI_MEM_WRITE_EN
                  8'h02: begin
                    state    <= S_ADDR;
                    is_write <= 1'b1;
                  end
`endif
                  default: begin
                    cmd_err <= 1'b1;
                    state   <= S_IGNORE;
                  end
                endcase
              end
            end
          end
          S_ADDR: begin
            if (rise) begin
              rx_shift <= rx_next[14:0];
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == 4'd15) begin
                bit_cnt <= '0;
                addr    <= rx_next[MEM_AW-1:0];
`ifdef SPI_MEM_WRITE_EN
                state   <= is_write ? S_WRITE : S_FETCH;
`else
                state   <= S_FETCH;
`endif
              end
            end
          end
          // The word is staged in both tx_shift and next_word with word_done set.
          // The first SCLK fall, which follows the last address bit, then reloads the word instead of shifting it.
          S_FETCH: begin
            tx_shift    <= mem_rdata;
            next_word   <= mem_rdata;
            word_done   <= 1'b1;
            spi_miso_oe <= 1'b1;
            state       <= S_READ;
          end
          S_READ: begin
            if (rise) begin
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 4'd15) begin
                bit_cnt    <= '0;
                addr       <= addr + 1'b1;
                pf_pending <= 1'b1;
                word_done  <= 1'b1;
              end
            end
            if (fall) begin
              if (word_done) begin
                tx_shift  <= next_word;
                word_done <= 1'b0;
              end else begin
                tx_shift <= {tx_shift[14:0], 1'b0};
              end
            end
          end
`ifdef SPI_MEM_WRITE_EN
          S_WRITE: begin
            if (rise) begin
              rx_shift <= rx_next[14:0];
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == 4'd15) begin
                bit_cnt    <= '0;
                wr_pending <= 1'b1;
                wr_addr    <= addr;
                wr_data    <= rx_next;
                addr       <= addr + 1'b1;
              end
            end
          end
`endif
          S_IGNORE: begin
            state <= S_IGNORE;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
